boot_loader: RTL and testbench
==============================

Name: boot_loader

Overview:
- Sequences the CPU bus and the control unit's bootload inputs to copy a program from an external byte stream into RAM before the CPU runs.
- Consumes bytes over a valid/ready handshake.
- For each byte, drives the address onto the bus and strobes bootload_address (MAR load), then drives the data and strobes bootload_ram (RAM write).
- Holds the CPU halted for the whole load; releases it when the last RAM location is written.

Parameters:
- ADDR_WIDTH, 4, RAM address width; RAM depth = 2**ADDR_WIDTH (16).
- DATA_WIDTH, 8, bus and byte width.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request to begin a load; sampled only in IDLE.
- abort  in  1  cancels a load in progress; returns to IDLE next edge.
- byte_valid  in  1  stream has a byte on byte_data.
- byte_data  in  DATA_WIDTH  program byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- bus_out  out  DATA_WIDTH  value driven onto the CPU bus; 0 when boot_write_to_bus=0.
- boot_write_to_bus  out  1  loader owns the bus this cycle.
- bootload_address  out  1  to control: MAR reads from bus.
- bootload_ram  out  1  to control: RAM reads from bus.
- cpu_hold  out  1  halts CPU clock/sequencing; high while busy.
- busy  out  1  load in progress (any state but IDLE).
- done  out  1  sticky: last load completed all 2**ADDR_WIDTH bytes.
- load_addr  out  ADDR_WIDTH  address of the byte currently being loaded.

Behaviour:
- Reset (rst=0 at an edge): state=IDLE, load_addr=0, data_reg=0, done=0, and all other outputs 0. Reset overrides start and abort.
- Outputs are Moore-style, decoded from registered state only. There is no combinational path from inputs to outputs.
- IDLE: busy=0, cpu_hold=0, byte_ready=0.
  - start=1 -> WAIT_BYTE; load_addr<=0; done<=0.
- WAIT_BYTE: byte_ready=1, busy=1, cpu_hold=1.
  - byte_valid=1 -> data_reg<=byte_data, go to SET_ADDR.
  - Otherwise stay; gaps of any length are allowed.
- SET_ADDR: exactly 1 cycle. bus_out={0,load_addr} zero-extended to DATA_WIDTH; boot_write_to_bus=1; bootload_address=1. Next state: WRITE_RAM.
- WRITE_RAM: exactly 1 cycle. bus_out=data_reg; boot_write_to_bus=1; bootload_ram=1.
  - If load_addr == 2**ADDR_WIDTH-1 -> DONE.
  - Else load_addr<=load_addr+1 -> WAIT_BYTE.
- DONE: 1 cycle. busy=1, cpu_hold=1; done<=1. Next state: IDLE.
- bootload_address and bootload_ram are never high in the same cycle. Each is high only alongside boot_write_to_bus.
- byte_ready is high only in WAIT_BYTE. Bytes presented in any other state are not consumed.
- Throughput: 3 cycles per byte minimum. With byte_valid held high, a full 16-byte load takes 1 (start edge) + 48 + 1 (DONE) cycles from start to done.
- abort=1 in any non-IDLE state -> IDLE next edge.
  - done stays 0, load_addr is reset to 0, cpu_hold drops.
  - RAM contents already written are left as is.
  - abort in IDLE has no effect.
- start while busy is ignored. start and abort together in IDLE -> start wins. start and abort together while busy -> abort wins.
- load_addr is incremented only in WRITE_RAM and never wraps within a load. The final address ends the load instead of wrapping.
- done stays high until the next accepted start, or reset.

Test Plan:
- Reset: hold rst=0 for 2 cycles with start=1 and byte_valid=1 -> state IDLE; all outputs 0; release with start=0 -> still IDLE, no byte_ready.
- Full load: start pulse, then byte_valid=1 with byte_data=0x10+i for i=0..15.
  - Per byte: bus sequence is addr i with bootload_address=1, then 0x10+i with bootload_ram=1.
  - done=1 and cpu_hold=0 exactly 50 cycles after start.
  - A RAM model holds 0x10..0x1F.
- Backpressure: byte_valid low for 5 cycles before byte 3 (0xA5) -> byte_ready stays high and no bus strobes during the gap; address 3 written with 0xA5.
- Start while busy: pulse start during byte 7 -> load_addr continues 7->8; done is not cleared early.
- Abort/reset mid-load: abort during SET_ADDR of byte 9 -> IDLE next cycle, done=0, cpu_hold=0. A new start reloads from address 0. Repeat the check with rst=0 instead of abort.
- Stray bytes: byte_valid=1 while in IDLE or DONE -> byte_ready=0 and no bus activity. The next start consumes the first byte only once in WAIT_BYTE.

Source files
------------

// File: rtl/boot_loader.sv
// Boot loader: copies a byte stream into CPU RAM through the shared bus,
// strobing the MAR load and then the RAM write for every byte, with the CPU held.
module boot_loader #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  byte_valid,
    input  logic [DATA_WIDTH-1:0] byte_data,
    output logic                  byte_ready,
    output logic [DATA_WIDTH-1:0] bus_out,
    output logic                  boot_write_to_bus,
    output logic                  bootload_address,
    output logic                  bootload_ram,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] load_addr
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_BYTE,
        S_SET_ADDR,
        S_WRITE_RAM,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic                  done_d;

    logic                  byte_ready_d;
    logic [DATA_WIDTH-1:0] bus_out_d;
    logic                  write_bus_d;
    logic                  load_mar_d;
    logic                  load_ram_d;
    logic                  busy_d;

    // State and output registers; outputs are decoded from the next state so
    // they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q           <= S_IDLE;
            data_q            <= '0;
            load_addr         <= '0;
            done              <= 1'b0;
            byte_ready        <= 1'b0;
            bus_out           <= '0;
            boot_write_to_bus <= 1'b0;
            bootload_address  <= 1'b0;
            bootload_ram      <= 1'b0;
            cpu_hold          <= 1'b0;
            busy              <= 1'b0;
        end else begin
            state_q           <= state_d;
            data_q            <= data_d;
            load_addr         <= addr_d;
            done              <= done_d;
            byte_ready        <= byte_ready_d;
            bus_out           <= bus_out_d;
            boot_write_to_bus <= write_bus_d;
            bootload_address  <= load_mar_d;
            bootload_ram      <= load_ram_d;
            cpu_hold          <= busy_d;
            busy              <= busy_d;
        end
    end

    // Next-state logic; abort beats everything once a load is running.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        addr_d  = load_addr;
        done_d  = done;
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            addr_d  = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_WAIT_BYTE;
                        addr_d  = '0;
                        done_d  = 1'b0;
                    end
                end
                S_WAIT_BYTE: begin
                    if (byte_valid) begin
                        data_d  = byte_data;
                        state_d = S_SET_ADDR;
                    end
                end
                S_SET_ADDR: begin
                    state_d = S_WRITE_RAM;
                end
                S_WRITE_RAM: begin
                    if (load_addr == LAST_ADDR) begin
                        state_d = S_DONE;
                    end else begin
                        addr_d  = load_addr + ADDR_WIDTH'(1);
                        state_d = S_WAIT_BYTE;
                    end
                end
                S_DONE: begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Output decode for the upcoming state.
    always_comb begin
        byte_ready_d = 1'b0;
        bus_out_d    = '0;
        write_bus_d  = 1'b0;
        load_mar_d   = 1'b0;
        load_ram_d   = 1'b0;
        busy_d       = (state_d != S_IDLE);
        unique case (state_d)
            S_WAIT_BYTE: byte_ready_d = 1'b1;
            S_SET_ADDR: begin
                bus_out_d   = DATA_WIDTH'(addr_d);
                write_bus_d = 1'b1;
                load_mar_d  = 1'b1;
            end
            S_WRITE_RAM: begin
                bus_out_d   = data_d;
                write_bus_d = 1'b1;
                load_ram_d  = 1'b1;
            end
            default: begin
                byte_ready_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: vector table for reset/handshake timing,
// then scripted loads with a bus scoreboard and a RAM model fed by the strobes.
module tb_boot_loader;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          rst, start, abort, byte_valid;
    logic [DW-1:0] byte_data;
    logic          byte_ready, boot_write_to_bus, bootload_address, bootload_ram;
    logic          cpu_hold, busy, done;
    logic [DW-1:0] bus_out;
    logic [AW-1:0] load_addr;

    always #5 clk = ~clk;

    boot_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .bus_out(bus_out), .boot_write_to_bus(boot_write_to_bus),
        .bootload_address(bootload_address), .bootload_ram(bootload_ram),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .load_addr(load_addr)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } sb_t;

    typedef struct {
        logic          rst, start, abort, valid;
        logic [DW-1:0] data;
        logic          rdy, busy, hold, done, wtb, ba, br;
        logic [DW-1:0] bus;
        logic [AW-1:0] la;
    } vec_t;

    sb_t           sb_q[$];
    logic [AW-1:0] sb_addr = '0;
    logic [DW-1:0] ram[16];
    logic [DW-1:0] mar = '0;
    bit            accepted;
    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    int            t0;
    vec_t          vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // One clock: log any handshake into the scoreboard, then check the bus.
    task automatic step();
        sb_t e;
        accepted = rst && !abort && byte_ready && byte_valid;
        if (accepted) begin
            sb_q.push_back(sb_t'({sb_addr, byte_data}));
            sb_addr++;
        end
        @(posedge clk);
        #1;
        cyc++;
        chk("strobe_exclusive", 32'(bootload_address && bootload_ram), 0);
        chk("strobe_needs_bus", 32'((bootload_address || bootload_ram) && !boot_write_to_bus), 0);
        chk("bus_zero_when_free", 32'(!boot_write_to_bus && (bus_out != '0)), 0);
        if (bootload_address) begin
            chk("addr_strobe_expected", 32'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) chk("addr_phase", 32'(bus_out), 32'(sb_q[0].addr));
            mar = bus_out;
        end
        if (bootload_ram) begin
            chk("ram_strobe_expected", 32'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("data_phase", 32'(bus_out), 32'(e.data));
            end
            ram[mar[AW-1:0]] = bus_out;
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        sb_addr = '0;
        sb_q.delete();
        step();
        start = 1'b0;
    endtask

    // Present a byte and clock until the loader takes it (bounded).
    task automatic send(input logic [DW-1:0] d);
        int n;
        n = 0;
        byte_valid = 1'b1;
        byte_data = d;
        accepted = 1'b0;
        while (!accepted && n < 20) begin
            step();
            n++;
        end
        chk("byte_accept_timeout", 32'(accepted), 1);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 60) begin
            step();
            n++;
        end
        chk("done_reached", 32'(done), 1);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; abort = 1'b0; byte_valid = 1'b0; byte_data = '0;
        for (int i = 0; i < 16; i++) ram[i] = '0;

        //          rst start abort valid data  | rdy busy hold done wtb ba br bus  la
        vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h3C, 4'd0};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd1};
        vecs[9] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0};

        for (int i = 0; i < 10; i++) begin
            rst = vecs[i].rst; start = vecs[i].start; abort = vecs[i].abort;
            byte_valid = vecs[i].valid; byte_data = vecs[i].data;
            step();
            chk($sformatf("vec%0d_ready", i), 32'(byte_ready), 32'(vecs[i].rdy));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
            chk($sformatf("vec%0d_hold", i), 32'(cpu_hold), 32'(vecs[i].hold));
            chk($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].done));
            chk($sformatf("vec%0d_wtb", i), 32'(boot_write_to_bus), 32'(vecs[i].wtb));
            chk($sformatf("vec%0d_baddr", i), 32'(bootload_address), 32'(vecs[i].ba));
            chk($sformatf("vec%0d_bram", i), 32'(bootload_ram), 32'(vecs[i].br));
            chk($sformatf("vec%0d_bus", i), 32'(bus_out), 32'(vecs[i].bus));
            chk($sformatf("vec%0d_addr", i), 32'(load_addr), 32'(vecs[i].la));
        end
        start = 1'b0; abort = 1'b0; byte_valid = 1'b0;
        sb_q.delete();

        // Full load with byte_valid held high; valid already up while idle.
        byte_valid = 1'b1; byte_data = 8'h10;
        step();
        chk("idle_stray_ready", 32'(byte_ready), 0);
        t0 = cyc;
        do_start();
        for (int i = 0; i < 16; i++) send(8'(8'h10 + i));
        byte_data = 8'hEE;
        wait_done();
        chk("done_latency", 32'(cyc - t0), 50);
        chk("hold_released", 32'(cpu_hold), 0);
        for (int i = 0; i < 16; i++) chk($sformatf("ram1_%0d", i), 32'(ram[i]), 32'(8'h10 + i));
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stray_ready", 32'(byte_ready), 0);
            chk("stray_busy", 32'(busy), 0);
            chk("done_sticky", 32'(done), 1);
        end

        // Backpressure before byte 3, start pulse while busy during byte 7.
        byte_data = 8'h20;
        do_start();
        chk("done_cleared_by_start", 32'(done), 0);
        for (int i = 0; i < 16; i++) begin
            if (i == 3) begin
                byte_valid = 1'b0;
                step();
                step();
                for (int g = 0; g < 5; g++) begin
                    step();
                    chk("gap_ready", 32'(byte_ready), 1);
                    chk("gap_no_strobe", 32'(bootload_address || bootload_ram), 0);
                end
                send(8'hA5);
            end else begin
                send(8'(8'h20 + i));
            end
            if (i == 7) begin
                start = 1'b1;
                step();
                start = 1'b0;
                chk("busy_start_addr7", 32'(load_addr), 7);
                chk("busy_start_done", 32'(done), 0);
                step();
                chk("busy_start_addr8", 32'(load_addr), 8);
                chk("busy_start_busy", 32'(busy), 1);
            end
        end
        byte_valid = 1'b0;
        wait_done();
        chk("ram2_3", 32'(ram[3]), 32'h A5);
        chk("ram2_7", 32'(ram[7]), 32'h27);
        chk("ram2_8", 32'(ram[8]), 32'h28);
        chk("ram2_15", 32'(ram[15]), 32'h2F);

        // Abort during SET_ADDR of byte 9, then reload from address 0.
        byte_valid = 1'b1;
        do_start();
        for (int i = 0; i < 10; i++) send(8'(8'h30 + i));
        chk("abort_at_set_addr", 32'(bootload_address), 1);
        chk("abort_at_addr9", 32'(load_addr), 9);
        abort = 1'b1;
        byte_valid = 1'b0;
        step();
        abort = 1'b0;
        sb_q.delete();
        chk("abort_busy", 32'(busy), 0);
        chk("abort_hold", 32'(cpu_hold), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_addr", 32'(load_addr), 0);
        chk("abort_ram9_kept", 32'(ram[9]), 32'h29);
        do_start();
        send(8'h40);
        send(8'h41);
        byte_valid = 1'b0;
        step();
        step();
        chk("reload_ram0", 32'(ram[0]), 32'h40);
        chk("reload_ram1", 32'(ram[1]), 32'h41);

        // Same interruption via reset instead of abort.
        rst = 1'b0;
        step();
        rst = 1'b1;
        sb_q.delete();
        byte_valid = 1'b1;
        do_start();
        for (int i = 0; i < 10; i++) send(8'(8'h50 + i));
        rst = 1'b0;
        step();
        rst = 1'b1;
        byte_valid = 1'b0;
        sb_q.delete();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_hold", 32'(cpu_hold), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_addr", 32'(load_addr), 0);
        chk("rst_bus", 32'(bus_out), 0);
        byte_valid = 1'b1;
        do_start();
        send(8'h60);
        byte_valid = 1'b0;
        step();
        chk("rst_reload_ram0", 32'(ram[0]), 32'h60);
        chk("rst_reload_addr", 32'(load_addr), 0);

        step();
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
